pong_match_ctrl: RTL and testbench

Match sequencer for the Pong console. It owns the game flow: attract/idle, serve countdown, live play, post-point pause and game over. It keeps both scores and drives `reset_game` and ball enable into the ball, paddle and AI-opponent blocks. It consumes the ball block's miss pulses and the video timing's once-per-frame tick.

---
 rtl/pong_match_ctrl.sv | 156 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: idle/attract, serve countdown, live play, post-point
// pause and game over. Keeps both scores and drives the ball/paddle enables.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 45,
  parameter int unsigned OVER_FRAMES  = 300
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       reset_game,
  output logic       ball_en,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN_VAL  = 4'(WIN_SCORE);
  localparam logic [8:0] SERVE_LD = 9'(SERVE_FRAMES);
  localparam logic [8:0] POINT_LD = 9'(POINT_FRAMES);
  localparam logic [8:0] OVER_LD  = 9'(OVER_FRAMES);

  state_t     st_q, st_d;
  logic [8:0] cnt_q, cnt_d;
  logic [3:0] p1_d, p2_d;
  logic       dir_d, win_d;
  logic       rg_d, be_d, go_d;
  logic       btn_prev_q;
  logic       start_edge;
  logic       cnt_last;

  assign start_edge = start_btn & ~btn_prev_q;
  assign cnt_last   = frame_tick & (cnt_q == 9'd1);
  assign state      = st_q;

  // State, counter, scores and Moore output registers
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      st_q       <= S_IDLE;
      cnt_q      <= '0;
      score_p1   <= '0;
      score_p2   <= '0;
      serve_dir  <= 1'b1;
      winner     <= 1'b0;
      reset_game <= 1'b1;
      ball_en    <= 1'b0;
      game_over  <= 1'b0;
      btn_prev_q <= 1'b1;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      score_p1   <= p1_d;
      score_p2   <= p2_d;
      serve_dir  <= dir_d;
      winner     <= win_d;
      reset_game <= rg_d;
      ball_en    <= be_d;
      game_over  <= go_d;
      btn_prev_q <= start_btn;
    end
  end

  // Next-state, counter and score update; outputs are decoded from the
  // next state so they register on the same edge as the state change
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    p1_d  = score_p1;
    p2_d  = score_p2;
    dir_d = serve_dir;
    win_d = winner;

    case (st_q)
      S_IDLE: begin
        if (start_edge) begin
          p1_d  = '0;
          p2_d  = '0;
          dir_d = 1'b1;
          win_d = 1'b0;
          cnt_d = SERVE_LD;
          st_d  = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_last) st_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (miss_left) begin
          p2_d  = score_p2 + 4'd1;
          dir_d = 1'b0;
          if (p2_d == WIN_VAL) begin
            win_d = 1'b1;
            cnt_d = OVER_LD;
            st_d  = S_OVER;
          end else begin
            cnt_d = POINT_LD;
            st_d  = S_POINT;
          end
        end else if (miss_right) begin
          p1_d  = score_p1 + 4'd1;
          dir_d = 1'b1;
          if (p1_d == WIN_VAL) begin
            win_d = 1'b0;
            cnt_d = OVER_LD;
            st_d  = S_OVER;
          end else begin
            cnt_d = POINT_LD;
            st_d  = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          if (cnt_last) begin
            cnt_d = SERVE_LD;
            st_d  = S_SERVE;
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
      end
      S_OVER: begin
        if (start_edge) begin
          st_d = S_IDLE;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_last) st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase

    rg_d = (st_d == S_IDLE) || (st_d == S_SERVE) || (st_d == S_OVER);
    be_d = (st_d == S_PLAY);
    go_d = (st_d == S_OVER);
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios plus a
// randomized run, all checked against a frame-level model of the match rules.
module tb_pong_match_ctrl;

  localparam int WS = 2;
  localparam int SF = 3;
  localparam int PF = 2;
  localparam int OF = 4;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  logic       clk_0;
  logic       rst;
  logic       frame_tick;
  logic       start_btn;
  logic       miss_left;
  logic       miss_right;
  logic       reset_game;
  logic       ball_en;
  logic       serve_dir;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  int total;
  int bad;

  // Model: match phase, frames left in the current phase, scores
  int m_mode;
  int m_left;
  int m_s1;
  int m_s2;
  bit m_dir;
  bit m_win;
  bit m_prev;

  logic [15:0] obs;
  assign obs = {state, reset_game, ball_en, serve_dir, score_p1, score_p2,
                game_over, winner};

  pong_match_ctrl #(
    .WIN_SCORE   (WS),
    .SERVE_FRAMES(SF),
    .POINT_FRAMES(PF),
    .OVER_FRAMES (OF)
  ) dut (
    .clk_0     (clk_0),
    .rst       (rst),
    .frame_tick(frame_tick),
    .start_btn (start_btn),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .reset_game(reset_game),
    .ball_en   (ball_en),
    .serve_dir (serve_dir),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .game_over (game_over),
    .winner    (winner),
    .state     (state)
  );

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  function automatic logic [15:0] exp_vec();
    logic rg, be, go;
    rg = (m_mode == M_IDLE) || (m_mode == M_SERVE) || (m_mode == M_OVER);
    be = (m_mode == M_PLAY);
    go = (m_mode == M_OVER);
    return {3'(m_mode), rg, be, m_dir, 4'(m_s1), 4'(m_s2), go, m_win};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0;
    m_dir = 1'b1; m_win = 1'b0; m_prev = 1'b1;
  endtask

  task automatic model_step(input bit ft, input bit sb, input bit ml, input bit mr);
    bit se;
    se = sb && !m_prev;
    m_prev = sb;
    case (m_mode)
      M_IDLE: if (se) begin
        m_s1 = 0; m_s2 = 0; m_dir = 1'b1; m_win = 1'b0;
        m_left = SF; m_mode = M_SERVE;
      end
      M_SERVE: if (ft) begin
        m_left--;
        if (m_left == 0) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (ml) begin
          m_s2++; m_dir = 1'b0;
          if (m_s2 == WS) begin m_win = 1'b1; m_left = OF; m_mode = M_OVER; end
          else begin m_left = PF; m_mode = M_POINT; end
        end else if (mr) begin
          m_s1++; m_dir = 1'b1;
          if (m_s1 == WS) begin m_win = 1'b0; m_left = OF; m_mode = M_OVER; end
          else begin m_left = PF; m_mode = M_POINT; end
        end
      end
      M_POINT: if (ft) begin
        m_left--;
        if (m_left == 0) begin m_left = SF; m_mode = M_SERVE; end
      end
      M_OVER: begin
        if (se) m_mode = M_IDLE;
        else if (ft) begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock: drive at the falling edge, model steps at the rising edge,
  // return at the next falling edge where outputs are sampled.
  task automatic tick(input bit ft, input bit sb, input bit ml, input bit mr);
    frame_tick = ft; start_btn = sb; miss_left = ml; miss_right = mr;
    @(posedge clk_0);
    model_step(ft, sb, ml, mr);
    @(negedge clk_0);
    frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
  endtask

  // Bounded run of frame ticks until the model reaches a phase
  task automatic run_to(input int mode);
    int n;
    n = 0;
    while (m_mode != mode && n < 200) begin
      tick(1'b1, start_btn, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (m_mode != mode) begin
      bad++;
      $display("FAIL run_to: phase %0d, wanted %0d within 200 cycles", m_mode, mode);
    end
  endtask

  task automatic start_game();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; start_btn = 1'b1; frame_tick = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_0);
    total++;
    if (obs !== 16'h1400) begin
      bad++; $display("FAIL reset_vals: got %h want %h", obs, 16'h1400);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'(i & 1), 1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL held_btn_idle: got %h want %h", obs, exp_vec());
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (state !== 3'd1 || obs !== exp_vec()) begin
      bad++; $display("FAIL press_to_serve: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_serve();
    int ticks, n;
    ticks = 0; n = 0;
    while (m_mode == M_SERVE && n < 100) begin
      bit ft;
      ft = ($urandom_range(0, 2) == 0);
      tick(ft, start_btn, 1'b0, 1'b0);
      if (ft) ticks++;
      n++;
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL serve_count: got %h want %h", obs, exp_vec());
      end
    end
    total++;
    if (ticks != SF || state !== 3'd2 || ball_en !== 1'b1) begin
      bad++;
      $display("FAIL serve_len: ticks %0d state %0d ball_en %b, want %0d/2/1",
               ticks, state, ball_en, SF);
    end
  endtask

  task automatic test_point();
    tick(1'b0, start_btn, 1'b0, 1'b1);
    total++;
    if (score_p1 !== 4'd1 || state !== 3'd3 || serve_dir !== 1'b1 || ball_en !== 1'b0) begin
      bad++; $display("FAIL miss_right: got %h want p1=1 st=3 dir=1 be=0", obs);
    end
    tick(1'b0, start_btn, 1'b1, 1'b0);
    for (int i = 0; i < PF; i++) begin
      tick(1'b1, start_btn, 1'b0, 1'b0);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL point_count: got %h want %h", obs, exp_vec());
      end
    end
    total++;
    if (state !== 3'd1 || score_p2 !== 4'd0) begin
      bad++; $display("FAIL point_to_serve: state %0d p2 %0d want 1/0", state, score_p2);
    end
  endtask

  task automatic test_simul_miss();
    run_to(M_PLAY);
    tick(1'b0, start_btn, 1'b1, 1'b1);
    total++;
    if (score_p1 !== 4'd1 || score_p2 !== 4'd1 || serve_dir !== 1'b0 || state !== 3'd3) begin
      bad++; $display("FAIL simul_miss: got %h want p1=1 p2=1 dir=0 st=3", obs);
    end
  endtask

  task automatic test_ignored_miss();
    tick(1'b0, start_btn, 1'b1, 1'b0);
    tick(1'b1, start_btn, 1'b0, 1'b1);
    run_to(M_SERVE);
    tick(1'b0, start_btn, 1'b1, 1'b1);
    tick(1'b0, start_btn, 1'b0, 1'b1);
    total++;
    if (score_p1 !== 4'd1 || score_p2 !== 4'd1 || obs !== exp_vec()) begin
      bad++; $display("FAIL ignored_miss: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_win();
    run_to(M_PLAY);
    tick(1'b0, start_btn, 1'b1, 1'b0);
    total++;
    if (score_p2 !== 4'd2 || state !== 3'd4 || game_over !== 1'b1 || winner !== 1'b1
        || reset_game !== 1'b1 || ball_en !== 1'b0) begin
      bad++; $display("FAIL p2_wins: got %h want p2=2 st=4 go=1 win=1", obs);
    end
    start_game();
    total++;
    if (state !== 3'd0 || score_p1 !== 4'd1 || score_p2 !== 4'd2 || winner !== 1'b1
        || game_over !== 1'b0) begin
      bad++; $display("FAIL over_start: got %h want st=0 p1=1 p2=2 win=1", obs);
    end
  endtask

  task automatic test_over_timeout();
    start_game();
    run_to(M_PLAY);
    tick(1'b0, start_btn, 1'b0, 1'b1);
    run_to(M_PLAY);
    tick(1'b0, start_btn, 1'b0, 1'b1);
    total++;
    if (state !== 3'd4 || winner !== 1'b0 || score_p1 !== 4'd2 || score_p2 !== 4'd0) begin
      bad++; $display("FAIL p1_wins: got %h want st=4 win=0 p1=2 p2=0", obs);
    end
    for (int i = 0; i < OF; i++) begin
      tick(1'b1, start_btn, 1'b0, 1'b0);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL over_count: got %h want %h", obs, exp_vec());
      end
    end
    total++;
    if (state !== 3'd0 || score_p1 !== 4'd2) begin
      bad++; $display("FAIL over_timeout: state %0d p1 %0d want 0/2", state, score_p1);
    end
  endtask

  task automatic test_async_reset();
    start_game();
    run_to(M_PLAY);
    tick(1'b0, start_btn, 1'b0, 1'b1);
    run_to(M_SERVE);
    tick(1'b1, start_btn, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (obs !== 16'h1400) begin
      bad++; $display("FAIL async_reset: got %h want %h", obs, 16'h1400);
    end
    model_reset();
    @(negedge clk_0);
    rst = 1'b1;
  endtask

  task automatic test_random();
    bit sb;
    sb = start_btn;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) sb = ~sb;
      tick($urandom_range(0, 3) == 0, sb,
           $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random cycle %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_serve();
    test_point();
    test_simul_miss();
    test_ignored_miss();
    test_win();
    test_over_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
